// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/execute/memory-read sequencer for the
// 9-bit core. Owns the program counter, gates register-file and data-memory
// write enables from the decoder outputs, and keeps saturating busy-cycle
// and retired-instruction counters for the top level.
module instr_sequencer #(
  parameter int             PCW      = 10,
  parameter logic [PCW-1:0] PROG_END = 10'h3FF,
  parameter int             CNTW     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            Branch,
  input  logic            MemtoReg,
  input  logic            MemWrite,
  input  logic            RegWrite,
  input  logic            alu_nz,
  input  logic [PCW-1:0]  target,
  output logic [PCW-1:0]  prog_ctr,
  output logic            ir_load,
  output logic            reg_we,
  output logic            mem_we,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] cycle_count,
  output logic [CNTW-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEMRD = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [PCW-1:0]  PC_ONE  = {{(PCW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_t          state_r;
  state_t          next_state_s;
  logic [PCW-1:0]  prog_ctr_r;
  logic [PCW-1:0]  pc_next_s;
  logic [CNTW-1:0] cycle_count_r;
  logic [CNTW-1:0] instr_count_r;
  logic            clr_s;
  logic            retire_s;
  logic            ir_load_s;
  logic            reg_we_s;
  logic            mem_we_s;
  logic            busy_s;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // Busy covers every state that is working on an instruction.
  assign busy_s = (state_r == FETCH) || (state_r == EXEC) || (state_r == MEMRD);

  // Next-state, next-PC and write-strobe decode; ldr defers its register write to MEMRD.
  always_comb begin
    next_state_s = state_r;
    pc_next_s    = prog_ctr_r;
    clr_s        = 1'b0;
    retire_s     = 1'b0;
    ir_load_s    = 1'b0;
    reg_we_s     = 1'b0;
    mem_we_s     = 1'b0;
    case (state_r)
      IDLE, HALT: begin
        if (start) begin
          next_state_s = FETCH;
          pc_next_s    = {PCW{1'b0}};
          clr_s        = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      FETCH: begin
        if (prog_ctr_r == PROG_END) begin
          next_state_s = HALT;
        end else begin
          ir_load_s    = 1'b1;
          next_state_s = EXEC;
        end
      end
      EXEC: begin
        if (MemtoReg) begin
          // ldr (and the illegal ldr+str encoding) waits a cycle for read data.
          next_state_s = MEMRD;
        end else begin
          // bnz raises RegWrite in the decoder but must never write.
          reg_we_s     = RegWrite & ~Branch;
          mem_we_s     = MemWrite;
          pc_next_s    = (Branch & alu_nz) ? target : (prog_ctr_r + PC_ONE);
          retire_s     = 1'b1;
          next_state_s = FETCH;
        end
      end
      MEMRD: begin
        reg_we_s     = 1'b1;
        pc_next_s    = prog_ctr_r + PC_ONE;
        retire_s     = 1'b1;
        next_state_s = FETCH;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, PC and counter registers; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      prog_ctr_r    <= {PCW{1'b0}};
      cycle_count_r <= {CNTW{1'b0}};
      instr_count_r <= {CNTW{1'b0}};
    end else begin
      state_r    <= next_state_s;
      prog_ctr_r <= pc_next_s;
      if (clr_s) begin
        cycle_count_r <= {CNTW{1'b0}};
        instr_count_r <= {CNTW{1'b0}};
      end else begin
        cycle_count_r <= busy_s   ? sat_inc(cycle_count_r) : cycle_count_r;
        instr_count_r <= retire_s ? sat_inc(instr_count_r) : instr_count_r;
      end
    end
  end

  assign prog_ctr    = prog_ctr_r;
  assign ir_load     = ir_load_s;
  assign reg_we      = reg_we_s;
  assign mem_we      = mem_we_s;
  assign busy        = busy_s;
  assign done        = (state_r == HALT);
  assign cycle_count = cycle_count_r;
  assign instr_count = instr_count_r;

endmodule
